// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with a per-register pending (scoreboard) bit and a live pending count.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and post-edge busy state to the read ports.
module regfile_sb #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_1,
    input  logic                 we_2,
    input  logic [AW-1:0]        write_reg1,
    input  logic [AW-1:0]        write_reg2,
    input  logic [WIDTH-1:0]     write_reg1_data,
    input  logic [WIDTH-1:0]     write_reg2_data,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_reg,
    input  logic [NRD*AW-1:0]    read_reg,
    output logic [NRD*WIDTH-1:0] read_out,
    output logic [NRD-1:0]       read_busy,
    output logic [AW:0]          busy_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;

    logic wr1_ok;
    logic wr2_ok;
    logic rsv_ok;
    logic cnt_inc;
    logic cnt_dec1;
    logic cnt_dec2;

    // Register 0 is hardwired to zero and addresses past DEPTH do not exist.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < DEPTH);
    endfunction

    assign wr1_ok = we_1 && addr_ok(write_reg1);
    assign wr2_ok = we_2 && addr_ok(write_reg2);
    assign rsv_ok = rsv_en && addr_ok(rsv_reg);

    // Writes retire a pending register; a coincident reservation is applied last so it wins.
    always_comb begin
        busy_next = busy;
        if (wr1_ok) busy_next[write_reg1] = 1'b0;
        if (wr2_ok) busy_next[write_reg2] = 1'b0;
        if (rsv_ok) busy_next[rsv_reg] = 1'b1;
    end

    // Count only real transitions: each distinct register that goes busy or goes free.
    always_comb begin
        cnt_inc  = rsv_ok && !busy[rsv_reg];
        cnt_dec1 = wr1_ok && busy[write_reg1] && !(rsv_ok && rsv_reg == write_reg1);
        cnt_dec2 = wr2_ok && busy[write_reg2] && !(rsv_ok && rsv_reg == write_reg2)
                   && !(wr1_ok && write_reg1 == write_reg2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr1_ok) mem[write_reg1] <= write_reg1_data;
            // Port 2 is assigned last so it takes precedence on a shared address.
            if (wr2_ok) mem[write_reg2] <= write_reg2_data;
            busy     <= busy_next;
            busy_cnt <= busy_cnt + {{AW{1'b0}}, cnt_inc}
                                 - {{AW{1'b0}}, cnt_dec1}
                                 - {{AW{1'b0}}, cnt_dec2};
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [AW-1:0] ra;
        logic          ra_ok;

        assign ra    = read_reg[k*AW +: AW];
        assign ra_ok = addr_ok(ra);

`ifdef REGFILE_BYPASS_EN
        assign read_out[k*WIDTH +: WIDTH] =
            !ra_ok                           ? '0              :
            (wr2_ok && write_reg2 == ra)     ? write_reg2_data :
            (wr1_ok && write_reg1 == ra)     ? write_reg1_data :
                                               mem[ra];
        assign read_busy[k] = ra_ok && busy_next[ra];
`else
        assign read_out[k*WIDTH +: WIDTH] = ra_ok ? mem[ra] : '0;
        assign read_busy[k] = ra_ok && busy[ra];
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters); expectations follow REGFILE_BYPASS_EN.
module tb_regfile_sb;

    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int NRD   = 2;
    localparam int AW    = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 we_1, we_2;
    logic [AW-1:0]        write_reg1, write_reg2;
    logic [WIDTH-1:0]     write_reg1_data, write_reg2_data;
    logic                 rsv_en;
    logic [AW-1:0]        rsv_reg;
    logic [NRD*AW-1:0]    read_reg;
    logic [NRD*WIDTH-1:0] read_out;
    logic [NRD-1:0]       read_busy;
    logic [AW:0]          busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) dut (
        .clk             (clk),
        .rst             (rst),
        .we_1            (we_1),
        .we_2            (we_2),
        .write_reg1      (write_reg1),
        .write_reg2      (write_reg2),
        .write_reg1_data (write_reg1_data),
        .write_reg2_data (write_reg2_data),
        .rsv_en          (rsv_en),
        .rsv_reg         (rsv_reg),
        .read_reg        (read_reg),
        .read_out        (read_out),
        .read_busy       (read_busy),
        .busy_cnt        (busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rdata(input int k);
        return read_out[k*WIDTH +: WIDTH];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we_1 = 1'b0; we_2 = 1'b0; rsv_en = 1'b0;
        write_reg1 = '0; write_reg2 = '0; rsv_reg = '0;
        write_reg1_data = '0; write_reg2_data = '0;
    endtask

    task automatic set_read(input int k, input logic [AW-1:0] a);
        read_reg[k*AW +: AW] = a;
        #1;
    endtask

    task automatic test_reset();
        idle();
        read_reg = '0;
        rst = 1'b1;
        we_1 = 1'b1; write_reg1 = 6'd4; write_reg1_data = 16'hDEAD;
        rsv_en = 1'b1; rsv_reg = 6'd4;
        tick();
        idle();
        tick();
        checks++;
        if (busy_cnt !== 7'd0) begin
            errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", busy_cnt);
        end
        for (int a = 0; a < DEPTH; a++) begin
            set_read(a % 2, 6'(a));
            checks++;
            if (rdata(a % 2) !== 16'h0000 || read_busy[a % 2] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_read addr %0d got %h/%b exp 0000/0", a, rdata(a % 2), read_busy[a % 2]);
            end
        end
    endtask

    task automatic test_reserve_write();
        idle();
        rsv_en = 1'b1; rsv_reg = 6'd5;
        tick();
        idle();
        set_read(0, 6'd5);
        checks++;
        if (busy_cnt !== 7'd1 || read_busy[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL rsv5 got cnt %0d busy %b exp 1/1", busy_cnt, read_busy[0]);
        end
        we_1 = 1'b1; write_reg1 = 6'd5; write_reg1_data = 16'hBEEF;
        tick();
        idle();
        #1;
        checks++;
        if (busy_cnt !== 7'd0 || rdata(0) !== 16'hBEEF || read_busy[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr5 got cnt %0d data %h busy %b exp 0/BEEF/0", busy_cnt, rdata(0), read_busy[0]);
        end
    endtask

    task automatic test_same_addr_write();
        idle();
        rsv_en = 1'b1; rsv_reg = 6'd7;
        tick();
        idle();
        checks++;
        if (busy_cnt !== 7'd1) begin
            errors++; $display("[TB] FAIL rsv7 got cnt %0d exp 1", busy_cnt);
        end
        we_1 = 1'b1; write_reg1 = 6'd7; write_reg1_data = 16'h1111;
        we_2 = 1'b1; write_reg2 = 6'd7; write_reg2_data = 16'h2222;
        tick();
        idle();
        set_read(1, 6'd7);
        checks++;
        if (rdata(1) !== 16'h2222 || read_busy[1] !== 1'b0 || busy_cnt !== 7'd0) begin
            errors++;
            $display("[TB] FAIL dual_wr7 got %h/%b cnt %0d exp 2222/0 cnt 0", rdata(1), read_busy[1], busy_cnt);
        end
    endtask

    task automatic test_rsv_write_conflict();
        idle();
        rsv_en = 1'b1; rsv_reg = 6'd3;
        we_1 = 1'b1; write_reg1 = 6'd3; write_reg1_data = 16'h00AA;
        tick();
        idle();
        set_read(0, 6'd3);
        checks++;
        if (rdata(0) !== 16'h00AA || read_busy[0] !== 1'b1 || busy_cnt !== 7'd1) begin
            errors++;
            $display("[TB] FAIL rsv_wr3 got %h/%b cnt %0d exp 00AA/1 cnt 1", rdata(0), read_busy[0], busy_cnt);
        end
    endtask

    task automatic test_busy_count();
        idle();
        rsv_en = 1'b1; rsv_reg = 6'd3;
        tick();
        checks++;
        if (busy_cnt !== 7'd1) begin
            errors++; $display("[TB] FAIL rsv_again got cnt %0d exp 1", busy_cnt);
        end
        rsv_reg = 6'd10;
        tick();
        checks++;
        if (busy_cnt !== 7'd2) begin
            errors++; $display("[TB] FAIL rsv10 got cnt %0d exp 2", busy_cnt);
        end
        idle();
        we_1 = 1'b1; write_reg1 = 6'd3;  write_reg1_data = 16'h0033;
        we_2 = 1'b1; write_reg2 = 6'd10; write_reg2_data = 16'h0100;
        rsv_en = 1'b1; rsv_reg = 6'd11;
        tick();
        idle();
        set_read(0, 6'd10);
        set_read(1, 6'd11);
        checks++;
        if (busy_cnt !== 7'd1 || read_busy !== 2'b10 || rdata(0) !== 16'h0100) begin
            errors++;
            $display("[TB] FAIL mixed got cnt %0d busy %b data %h exp 1/10/0100", busy_cnt, read_busy, rdata(0));
        end
        we_1 = 1'b1; write_reg1 = 6'd11; write_reg1_data = 16'h0B0B;
        tick();
        idle();
        #1;
        checks++;
        if (busy_cnt !== 7'd0 || rdata(1) !== 16'h0B0B || read_busy[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr11 got cnt %0d data %h busy %b exp 0/0B0B/0", busy_cnt, rdata(1), read_busy[1]);
        end
    endtask

    task automatic test_reg0();
        idle();
        we_1 = 1'b1; write_reg1 = 6'd0; write_reg1_data = 16'hFFFF;
        we_2 = 1'b1; write_reg2 = 6'd0; write_reg2_data = 16'hFFFF;
        rsv_en = 1'b1; rsv_reg = 6'd0;
        set_read(0, 6'd0);
        set_read(1, 6'd0);
        tick();
        idle();
        #1;
        checks++;
        if (read_out !== 32'h0 || read_busy !== 2'b00 || busy_cnt !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reg0 got %h busy %b cnt %0d exp 0/00/0", read_out, read_busy, busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        rsv_en = 1'b1; rsv_reg = 6'd20;
        tick();
        rsv_reg = 6'd21;
        tick();
        checks++;
        if (busy_cnt !== 7'd2) begin
            errors++; $display("[TB] FAIL pre_rst got cnt %0d exp 2", busy_cnt);
        end
        rst = 1'b1;
        rsv_reg = 6'd22;
        we_1 = 1'b1; write_reg1 = 6'd23; write_reg1_data = 16'h7777;
        tick();
        idle();
        set_read(0, 6'd7);
        set_read(1, 6'd23);
        checks++;
        if (busy_cnt !== 7'd0 || read_out !== 32'h0 || read_busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL mid_rst got cnt %0d data %h busy %b exp 0/0/00", busy_cnt, read_out, read_busy);
        end
        we_1 = 1'b1; write_reg1 = 6'd20; write_reg1_data = 16'h5555;
        set_read(0, 6'd20);
        tick();
        idle();
        #1;
        checks++;
        if (rdata(0) !== 16'h5555 || read_busy[0] !== 1'b0 || busy_cnt !== 7'd0) begin
            errors++;
            $display("[TB] FAIL post_rst_wr got %h/%b cnt %0d exp 5555/0 cnt 0", rdata(0), read_busy[0], busy_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_data;
        logic             exp_busy;
        idle();
        set_read(0, 6'd9);
        we_1 = 1'b1; write_reg1 = 6'd9; write_reg1_data = 16'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_data = 16'h1234;
`else
        exp_data = 16'h0000;
`endif
        checks++;
        if (rdata(0) !== exp_data) begin
            errors++; $display("[TB] FAIL fwd9 got %h exp %h", rdata(0), exp_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata(0) !== 16'h1234) begin
            errors++; $display("[TB] FAIL stored9 got %h exp 1234", rdata(0));
        end
        rsv_en = 1'b1; rsv_reg = 6'd12;
        tick();
        idle();
        set_read(1, 6'd12);
        we_1 = 1'b1; write_reg1 = 6'd12; write_reg1_data = 16'hAAAA;
        we_2 = 1'b1; write_reg2 = 6'd12; write_reg2_data = 16'hC0DE;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_data = 16'hC0DE;
        exp_busy = 1'b0;
`else
        exp_data = 16'h0000;
        exp_busy = 1'b1;
`endif
        checks++;
        if (rdata(1) !== exp_data || read_busy[1] !== exp_busy) begin
            errors++;
            $display("[TB] FAIL fwd12 got %h/%b exp %h/%b", rdata(1), read_busy[1], exp_data, exp_busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rdata(1) !== 16'hC0DE || read_busy[1] !== 1'b0 || busy_cnt !== 7'd0) begin
            errors++;
            $display("[TB] FAIL stored12 got %h/%b cnt %0d exp C0DE/0 cnt 0", rdata(1), read_busy[1], busy_cnt);
        end
    endtask

    initial begin
        idle();
        read_reg = '0;
        test_reset();
        test_reserve_write();
        test_same_addr_write();
        test_rsv_write_conflict();
        test_busy_count();
        test_reg0();
        test_reset_mid();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of registers; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..8).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports we_1, input, 1, and we_2, input, 1, write enables for write ports 1 and 2.
REQ-007 SHALL have ports write_reg1, input, AW, and write_reg2, input, AW, write addresses.
REQ-008 SHALL have ports write_reg1_data, input, WIDTH, and write_reg2_data, input, WIDTH, write data.
REQ-009 SHALL have port rsv_en, input, 1, reserve request marking a destination register pending.
REQ-010 SHALL have port rsv_reg, input, AW, register to reserve.
REQ-011 SHALL have port read_reg, input, NRD*AW, packed read addresses; port k uses bits [k*AW +: AW].
REQ-012 SHALL have port read_out, output, NRD*WIDTH, packed read data; port k uses bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port read_busy, output, NRD, pending flag of each read port's register.
REQ-014 SHALL have port busy_cnt, output, AW+1, number of registers currently pending.

Function
REQ-015 Register 0 SHALL read as zero with read_busy 0; writes and reservations to address 0 SHALL be ignored.
REQ-016 Reads SHALL be combinational: read_out[k] = file[read_reg[k]], read_busy[k] = busy[read_reg[k]].
REQ-017 A write with weN=1 to nonzero address A SHALL update file[A] and clear busy[A] at the next edge.
REQ-018 When both write ports target the same nonzero address in one cycle, port 2 data SHALL be stored; busy SHALL be cleared.
REQ-019 rsv_en=1 to nonzero address A SHALL set busy[A] at the next edge.
REQ-020 When a reservation and a write target the same address in one cycle, busy SHALL end set (reservation wins); data SHALL still be written.
REQ-021 Reserving an already-busy register SHALL leave it busy with busy_cnt unchanged.
REQ-022 busy_cnt SHALL be a registered count equal to the number of set busy bits after each edge; maximum value DEPTH-1.
REQ-023 busy_cnt SHALL be updated incrementally in the same edge (+1 new reservation, -1 per distinct busy register cleared, net of coincident events), never wrapping.
REQ-024 Out-of-range addresses (>= DEPTH for non-power-of-2 DEPTH) SHALL be ignored for writes/reservations; reads of them SHALL return zero, busy 0.

Reset
REQ-025 rst=1 at a rising edge SHALL clear all file entries to zero, all busy bits, and busy_cnt to 0, overriding any write or reservation that cycle.
REQ-026 After reset all read_out SHALL be zero and all read_busy 0; no initial blocks SHALL be relied on.
REQ-027 Reset asserted mid-operation SHALL discard all pending reservations; a write in the following cycle SHALL behave normally.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-029 With REGFILE_BYPASS_EN defined, a read matching a same-cycle write address SHALL return that write data (port 2 over port 1) and read_busy SHALL show the post-edge busy value.
REQ-030 Without REGFILE_BYPASS_EN, reads SHALL return only stored state; same-cycle writes become visible the next cycle.

Verification
REQ-031 Reset, then read all addresses -> read_out 0, read_busy 0, busy_cnt 0.
REQ-032 rsv_en, rsv_reg=5; next cycle we_1, write_reg1=5, data 16'hBEEF -> busy_cnt 1 then 0; read_reg 5 gives 16'hBEEF, busy 0.
REQ-033 we_1 and we_2 both to reg 7, data 16'h1111/16'h2222 -> reg 7 reads 16'h2222.
REQ-034 Reserve reg 3 while we_1 writes reg 3 with 16'h00AA -> reg 3 reads 16'h00AA, read_busy 1, busy_cnt 1.
REQ-035 Write 16'hFFFF to reg 0 and reserve reg 0 -> reads 0, busy 0, busy_cnt 0.
REQ-036 With REGFILE_BYPASS_EN, we_1 to reg 9 with 16'h1234 while read_reg port 0 = 9 -> read_out port 0 = 16'h1234 in that cycle; without the macro -> old value, 16'h1234 next cycle.
